// File: rtl/apple_spawn_ctrl_pkg.sv
// Shared game definitions: FSM states, coordinate types and default geometry
// used by the apple, snake-head and renderer blocks.
package apple_spawn_ctrl_pkg;

  typedef logic [9:0]  coord_t;
  typedef logic [10:0] coord_ext_t;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SAMPLE_X = 3'd1,
    ST_SAMPLE_Y = 3'd2,
    ST_CHECK    = 3'd3,
    ST_SHOWN    = 3'd4,
    ST_COOLDOWN = 3'd5
  } state_e;

  localparam int APPLE_SIZE_DEF   = 15;
  localparam int HEAD_SIZE_DEF    = 15;
  localparam int H_OFF_DEF        = 170;
  localparam int V_OFF_DEF        = 60;
  localparam int MAX_RETRY_DEF    = 7;
  localparam int COOLDOWN_CYC_DEF = 3;

  // Edge + size widened by one bit so box comparisons can never wrap.
  function automatic coord_ext_t ext_add(input coord_t base, input coord_t delta);
    return {1'b0, base} + {1'b0, delta};
  endfunction

endpackage

// File: rtl/apple_spawn_ctrl_box_overlap.sv
// Combinational axis-aligned bounding-box intersection test (inclusive edges).
module box_overlap
  import apple_spawn_ctrl_pkg::*;
(
  input  coord_ext_t a_l,
  input  coord_ext_t a_r,
  input  coord_ext_t a_u,
  input  coord_ext_t a_d,
  input  coord_ext_t b_l,
  input  coord_ext_t b_r,
  input  coord_ext_t b_u,
  input  coord_ext_t b_d,
  output logic       hit
);

  assign hit = (a_l <= b_r) && (a_r >= b_l) && (a_u <= b_d) && (a_d >= b_u);

endmodule

// File: rtl/apple_spawn_ctrl.sv
// Apple life-cycle sequencer: samples a position from the random source, avoids
// the snake head, shows the apple, detects eating and respawns after a cooldown.
module apple_spawn_ctrl
  import apple_spawn_ctrl_pkg::*;
#(
  parameter int APPLE_SIZE   = APPLE_SIZE_DEF,
  parameter int HEAD_SIZE    = HEAD_SIZE_DEF,
  parameter int H_OFF        = H_OFF_DEF,
  parameter int V_OFF        = V_OFF_DEF,
  parameter int MAX_RETRY    = MAX_RETRY_DEF,
  parameter int COOLDOWN_CYC = COOLDOWN_CYC_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       game_over,
  // Random source; "rand" itself is a reserved word.
  input  logic [7:0] rand_in,
  input  logic [9:0] head_l,
  input  logic [9:0] head_u,
  output logic [9:0] Hl,
  output logic [9:0] Hr,
  output logic [9:0] Vu,
  output logic [9:0] Vd,
  output logic       apple_valid,
  output logic       eaten,
  output logic [7:0] score
);

  localparam coord_t     APPLE_SZ    = coord_t'(APPLE_SIZE);
  localparam coord_t     HEAD_SZ     = coord_t'(HEAD_SIZE);
  localparam coord_t     H_OFF_C     = coord_t'(H_OFF);
  localparam coord_t     V_OFF_C     = coord_t'(V_OFF);
  localparam logic [7:0] MAX_RETRY_C = 8'(MAX_RETRY);
  localparam logic       COOL_SKIP   = (COOLDOWN_CYC == 0);
  localparam logic [7:0] COOL_LAST   = (COOLDOWN_CYC > 0) ? 8'(COOLDOWN_CYC - 1) : 8'd0;

  state_e     state_q, state_d;
  coord_t     cand_l_q, cand_l_d;
  coord_t     cand_u_q, cand_u_d;
  coord_t     hl_q, hl_d, hr_q, hr_d, vu_q, vu_d, vd_q, vd_d;
  logic       valid_q, valid_d;
  logic       eaten_q, eaten_d;
  logic [7:0] score_q, score_d;
  logic [7:0] retry_q, retry_d;
  logic [7:0] cool_q, cool_d;
  logic       check_hit_s;
  logic       eat_hit_s;

  box_overlap u_check_overlap (
    .a_l (coord_ext_t'({1'b0, cand_l_q})),
    .a_r (ext_add(cand_l_q, APPLE_SZ)),
    .a_u (coord_ext_t'({1'b0, cand_u_q})),
    .a_d (ext_add(cand_u_q, APPLE_SZ)),
    .b_l (coord_ext_t'({1'b0, head_l})),
    .b_r (ext_add(head_l, HEAD_SZ)),
    .b_u (coord_ext_t'({1'b0, head_u})),
    .b_d (ext_add(head_u, HEAD_SZ)),
    .hit (check_hit_s)
  );

  box_overlap u_eat_overlap (
    .a_l (coord_ext_t'({1'b0, hl_q})),
    .a_r (coord_ext_t'({1'b0, hr_q})),
    .a_u (coord_ext_t'({1'b0, vu_q})),
    .a_d (coord_ext_t'({1'b0, vd_q})),
    .b_l (coord_ext_t'({1'b0, head_l})),
    .b_r (ext_add(head_l, HEAD_SZ)),
    .b_u (coord_ext_t'({1'b0, head_u})),
    .b_d (ext_add(head_u, HEAD_SZ)),
    .hit (eat_hit_s)
  );

  // Next-state and next-output logic; the stop override outranks everything.
  always_comb begin
    state_d  = state_q;
    cand_l_d = cand_l_q;
    cand_u_d = cand_u_q;
    hl_d     = hl_q;
    hr_d     = hr_q;
    vu_d     = vu_q;
    vd_d     = vd_q;
    valid_d  = valid_q;
    eaten_d  = 1'b0;
    score_d  = score_q;
    retry_d  = retry_q;
    cool_d   = cool_q;

    if ((state_q != ST_IDLE) && (!start || game_over)) begin
      state_d = ST_IDLE;
      hl_d    = 10'd0;
      hr_d    = 10'd0;
      vu_d    = 10'd0;
      vd_d    = 10'd0;
      valid_d = 1'b0;
      retry_d = 8'd0;
      cool_d  = 8'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start && !game_over) begin
            state_d = ST_SAMPLE_X;
            score_d = 8'd0;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_SAMPLE_X: begin
          cand_l_d = {1'b0, rand_in, 1'b0} + H_OFF_C;
          state_d  = ST_SAMPLE_Y;
        end
        ST_SAMPLE_Y: begin
          cand_u_d = {2'b00, rand_in} + V_OFF_C;
          state_d  = ST_CHECK;
        end
        ST_CHECK: begin
          if (check_hit_s && (retry_q < MAX_RETRY_C)) begin
            retry_d = retry_q + 8'd1;
            state_d = ST_SAMPLE_X;
          end else begin
            hl_d    = cand_l_q;
            hr_d    = cand_l_q + APPLE_SZ;
            vu_d    = cand_u_q;
            vd_d    = cand_u_q + APPLE_SZ;
            valid_d = 1'b1;
            retry_d = 8'd0;
            state_d = ST_SHOWN;
          end
        end
        ST_SHOWN: begin
          if (eat_hit_s) begin
            eaten_d = 1'b1;
            score_d = (score_q == 8'hFF) ? score_q : score_q + 8'd1;
            hl_d    = 10'd0;
            hr_d    = 10'd0;
            vu_d    = 10'd0;
            vd_d    = 10'd0;
            valid_d = 1'b0;
            cool_d  = 8'd0;
            if (COOL_SKIP) begin
              state_d = ST_SAMPLE_X;
            end else begin
              state_d = ST_COOLDOWN;
            end
          end else begin
            state_d = ST_SHOWN;
          end
        end
        ST_COOLDOWN: begin
          if (cool_q >= COOL_LAST) begin
            cool_d  = 8'd0;
            state_d = ST_SAMPLE_X;
          end else begin
            cool_d  = cool_q + 8'd1;
            state_d = ST_COOLDOWN;
          end
        end
        default: begin
          state_d = ST_IDLE;
          hl_d    = 10'd0;
          hr_d    = 10'd0;
          vu_d    = 10'd0;
          vd_d    = 10'd0;
          valid_d = 1'b0;
          retry_d = 8'd0;
          cool_d  = 8'd0;
        end
      endcase
    end
  end

  // State and output registers, cleared asynchronously by rst_n.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cand_l_q <= 10'd0;
      cand_u_q <= 10'd0;
      hl_q     <= 10'd0;
      hr_q     <= 10'd0;
      vu_q     <= 10'd0;
      vd_q     <= 10'd0;
      valid_q  <= 1'b0;
      eaten_q  <= 1'b0;
      score_q  <= 8'd0;
      retry_q  <= 8'd0;
      cool_q   <= 8'd0;
    end else begin
      state_q  <= state_d;
      cand_l_q <= cand_l_d;
      cand_u_q <= cand_u_d;
      hl_q     <= hl_d;
      hr_q     <= hr_d;
      vu_q     <= vu_d;
      vd_q     <= vd_d;
      valid_q  <= valid_d;
      eaten_q  <= eaten_d;
      score_q  <= score_d;
      retry_q  <= retry_d;
      cool_q   <= cool_d;
    end
  end

  assign Hl          = hl_q;
  assign Hr          = hr_q;
  assign Vu          = vu_q;
  assign Vd          = vd_q;
  assign apple_valid = valid_q;
  assign eaten       = eaten_q;
  assign score       = score_q;

endmodule

// File: doc/apple_spawn_ctrl.md
# apple_spawn_ctrl

Sequencer for the snake game's apple object. It owns the apple's life cycle:
- samples the shared 8-bit random source into a candidate position;
- rejects candidates that overlap the snake head;
- holds the accepted apple box for the VGA renderer;
- detects the head eating the apple, then schedules a respawn after a cooldown.

It sits between the LFSR and the pixel renderer, and replaces free-running combinational apple placement with a clocked FSM.

## Interface
Parameters:
- APPLE_SIZE, 15: apple box width/height minus one, in pixels.
- HEAD_SIZE, 15: snake head box width/height minus one, in pixels.
- H_OFF, 170: horizontal placement offset.
- V_OFF, 60: vertical placement offset.
- MAX_RETRY, 7: number of rejected candidates tolerated before a forced accept.
- COOLDOWN_CYC, 3: cycles between eat and resample (0 allowed).

Ports:
- clk, in, 1: single game clock; all state changes on its rising edge.
- rst_n, in, 1: reset, asynchronous, active-low.
- start, in, 1: game running level.
- game_over, in, 1: level; forces idle.
- rand, in, 8: random value, may change every cycle.
- head_l, in, 10: snake head left edge.
- head_u, in, 10: snake head top edge.
- Hl, Hr, Vu, Vd, out, 10 each: apple box edges; all 0 when no apple is shown.
- apple_valid, out, 1: apple currently shown.
- eaten, out, 1: one-cycle pulse per eat.
- score, out, 8: apples eaten, saturating.

## Operation
- States: IDLE, SAMPLE_X, SAMPLE_Y, CHECK, SHOWN, COOLDOWN.
- IDLE:
  - start=1 and game_over=0 -> SAMPLE_X; score clears on this transition.
- SAMPLE_X:
  - cand_l <= rand*2 + H_OFF, computed as a 10-bit zero-extended sum.
  - Next state SAMPLE_Y.
- SAMPLE_Y:
  - cand_u <= rand + V_OFF.
  - Next state CHECK.
- CHECK: the overlap test is cand_l <= head_l+HEAD_SIZE && cand_l+APPLE_SIZE >= head_l && cand_u <= head_u+HEAD_SIZE && cand_u+APPLE_SIZE >= head_u. All comparisons use 11-bit sums, so there is no wrap.
  - Overlap and retry < MAX_RETRY: retry+1, go to SAMPLE_X.
  - No overlap, or retry == MAX_RETRY: load the outputs, clear retry, go to SHOWN.
- SHOWN:
  - Outputs are Hl=cand_l, Hr=cand_l+APPLE_SIZE, Vu=cand_u, Vd=cand_u+APPLE_SIZE; apple_valid=1.
  - Each cycle, the same overlap test runs against the registered apple box.
  - On a hit: eaten=1 for the next cycle only, score+1 (saturating at 255), outputs cleared to 0, apple_valid=0, go to COOLDOWN (or SAMPLE_X if COOLDOWN_CYC=0).
- COOLDOWN: counts COOLDOWN_CYC cycles, then goes to SAMPLE_X.
- Override: in any state other than IDLE, start=0 or game_over=1 sends the FSM to IDLE next cycle.
  - Outputs 0, apple_valid 0, retry/cooldown counters cleared.
  - score is held, so the final score remains readable.
  - Override has priority over eat detection in the same cycle: no eaten pulse, no score change.

## Timing
- Reset (rst_n=0, async):
  - state IDLE;
  - Hl=Hr=Vu=Vd=0;
  - apple_valid=0, eaten=0, score=0;
  - retry=0, cooldown=0.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Spawn latency: start sampled high at edge N gives apple_valid=1 and a valid box after edge N+4, assuming a first-try accept. Each retry adds 3 cycles.
- Eat latency: head overlaps at edge M; eaten, the score change and the cleared box take effect after edge M+1. The next apple appears after edge M+1+COOLDOWN_CYC+3 (no retries).
- Corner cases:
  - rand=255 gives cand_l=680 and cand_u=315; these values fit 10 bits and must not be truncated.
  - At score=255, further eats still pulse eaten; score stays 255.
- Reset asserted mid-operation clears everything immediately, without waiting for a clock edge.

## Structure
- A shared game package holds:
  - the state enum;
  - the 10-bit coordinate type;
  - the default size and offset constants, also used by the head and renderer blocks.
- One sub-module, box_overlap: a combinational AABB test with two boxes in and a hit bit out. It is instantiated twice (CHECK test and eat test).

## Test plan
- Reset -> all outputs 0. Then start=1, rand=10 then 20, head at (0,0) -> after 4 edges: Hl=190, Hr=205, Vu=80, Vd=95, apple_valid=1.
- Head at (190,80) while SHOWN -> one cycle later eaten=1 for exactly 1 cycle, score=1, box=0. With COOLDOWN_CYC=3, the new apple is valid 6 edges after the eaten pulse.
- Head at (180,70), rand held at 10 -> retries 7 times, then forced accept at (190,80). apple_valid rises after 3×8+1 edges.
- game_over=1 in the same cycle the head overlaps the apple -> IDLE, no eaten pulse, score unchanged, box=0.
- rand=255 for both samples, head far away -> Hl=680, Hr=695, Vu=315, Vd=330.
- 256 eats -> score saturates at 255 and eaten still pulses. rst_n pulsed low mid-COOLDOWN -> outputs zero immediately, without a clock edge.
